// File: rtl/alu_mul_seq.sv
// Shift-add multiplier controller that sequences an external combinational ALU slice array.
// Optional ALU_MUL_SKIP_EN: bypasses ADD for iterations whose multiplier bit is zero.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_f,
  input  logic               alu_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XFER = 4'b0000;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 c_q, c_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cnt_inc;
  logic [2*WIDTH-1:0]   product_q, product_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_sel   = SEL_XFER;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a_in;
          q_d     = b_in;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        alu_sel = q_q[0] ? SEL_ADD : SEL_XFER;
        acc_d   = alu_f;
        c_d     = q_q[0] & alu_cout;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {c_d, acc_d, q_d} = {1'b0, c_q, acc_q, q_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(WIDTH)) begin
          state_d = S_DONE;
        end else begin
`ifdef ALU_MUL_SKIP_EN
          // A zero bit arriving at Q[0] would only transfer ACC; shift again instead.
          state_d = q_d[0] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_DONE: begin
        product_d = {acc_q, q_q};
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign alu_a   = acc_q;
  assign alu_b   = m_q;
  assign alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and a schedule/product reference model.
module tb_alu_mul_seq;

  localparam int W = 4;
`ifdef ALU_MUL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic [W-1:0]   alu_a, alu_b, alu_f;
  logic           alu_cin, alu_cout;
  logic [3:0]     alu_sel;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] held_prod = '0;
  logic [3:0]     exp_sel [0:63];
  int             exp_done;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  // Combinational ALU slice array: ADD or TRANSFER.
  always_comb begin
    if (alu_sel == 4'b0010) begin
      {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
    end else begin
      alu_cout = 1'b0;
      alu_f    = alu_a;
    end
  end

  // Expected cycle-by-cycle select code and done cycle, from the multiplier bits alone.
  task automatic build_schedule(input logic [W-1:0] b);
    int c;
    for (int i = 0; i < 64; i++) exp_sel[i] = 4'b0000;
    c = 1;
    for (int i = 0; i < W; i++) begin
      if (SKIP && i > 0 && !b[i]) begin
        c += 1;
      end else begin
        exp_sel[c] = b[i] ? 4'b0010 : 4'b0000;
        c += 2;
      end
    end
    exp_done = c;
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit b2b, input int glitch_cyc, input string name);
    logic [2*W-1:0] exp_prod;
    logic [2*W-1:0] want_p;
    exp_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    build_schedule(b);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      @(negedge clk);
      want_p = (cyc <= exp_done) ? held_prod : exp_prod;
      checks++;
      if (busy !== (cyc <= exp_done)) begin
        errors++;
        $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy, (cyc <= exp_done));
      end
      checks++;
      if (done !== (cyc == exp_done)) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done, (cyc == exp_done));
      end
      checks++;
      if (alu_sel !== exp_sel[cyc]) begin
        errors++;
        $display("FAIL %s alu_sel cyc%0d: got %b want %b", name, cyc, alu_sel, exp_sel[cyc]);
      end
      checks++;
      if (alu_b !== a || alu_cin !== 1'b0) begin
        errors++;
        $display("FAIL %s alu_b/cin cyc%0d: got %h/%b want %h/0", name, cyc, alu_b, alu_cin, a);
      end
      checks++;
      if (product !== want_p) begin
        errors++;
        $display("FAIL %s product cyc%0d: got %h want %h", name, cyc, product, want_p);
      end
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        a_in  = 4'h2;
        b_in  = 4'h2;
      end else if (cyc == glitch_cyc + 1) begin
        start = 1'b0;
        a_in  = a;
        b_in  = b;
      end
    end
    held_prod = exp_prod;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || alu_sel !== 4'b0000 ||
        alu_a !== '0 || alu_b !== '0 || alu_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b prod=%h sel=%b a=%h b=%h cin=%b want all 0",
               busy, done, product, alu_sel, alu_a, alu_b, alu_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held_prod = '0;
  endtask

  task automatic test_full_ones();
    run_mul(4'hF, 4'hF, 1'b0, -1, "f_x_f");
    checks++;
    if (held_prod !== 8'hE1) begin
      errors++;
      $display("FAIL f_x_f model: got %h want e1", held_prod);
    end
  endtask

  task automatic test_sparse_multiplier();
    run_mul(4'h1, 4'h9, 1'b0, -1, "1_x_9");
  endtask

  task automatic test_zero_multiplier();
    run_mul(4'h7, 4'h0, 1'b0, -1, "7_x_0");
    checks++;
    if (exp_done !== (SKIP ? 6 : 9)) begin
      errors++;
      $display("FAIL 7_x_0 latency model: got %0d want %0d", exp_done, (SKIP ? 6 : 9));
    end
  endtask

  task automatic test_start_ignored();
    run_mul(4'h3, 4'h5, 1'b0, 3, "3_x_5_glitch");
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 4'hA;
    b_in  = 4'hB;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || alu_sel !== 4'b0000 ||
        alu_a !== '0 || alu_b !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b prod=%h sel=%b a=%h b=%h want all 0",
               busy, done, product, alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held_prod = '0;
    run_mul(4'hA, 4'hB, 1'b0, -1, "a_x_b_after_reset");
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 256; i++) begin
      run_mul(W'(i >> 4), W'(i), (i != 0), -1, "sweep");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_mul(ra, rb, 1'($urandom_range(0, 1)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_full_ones();
    test_sparse_multiplier();
    test_zero_multiplier();
    test_start_ignored();
    test_async_reset();
    test_exhaustive();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
